modred_digit_serial: RTL and testbench

//  Digit-serial modular reducer: reduces an IN_W-bit unsigned operand mod Q, one DIGIT_W-bit digit per cycle.

---
 rtl/modred_pkg.sv | 40 ++++
 rtl/modred_weight_rom.sv | 33 +++
 rtl/modred_digit_serial.sv | 124 ++++++++++++
 tb/tb_modred_digit_serial.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modred_pkg.sv
// Shared definitions for the digit-serial modular reducer:
// FSM state type and elaboration-time helpers that build the digit weight tables.
package modred_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // 2^k mod q by repeated doubling; q must stay below 2^63 so the shift cannot overflow.
  function automatic logic [63:0] pow2_mod(input int k, input logic [63:0] q);
    logic [63:0] r;
    r = 64'd1;
    for (int j = 0; j < k; j++) begin
      r = r << 1;
      if (r >= q) r = r - q;
    end
    return r;
  endfunction

  // T[i][d] = (d * (2^(digit_w*i) mod q)) mod q, built from modular additions only.
  function automatic logic [63:0] table_entry(input int i, input int d, input int digit_w,
                                              input logic [63:0] q);
    logic [63:0] w;
    logic [63:0] acc;
    w   = pow2_mod(digit_w * i, q);
    acc = 64'd0;
    for (int j = 0; j < d; j++) begin
      acc = acc + w;
      if (acc >= q) acc = acc - q;
    end
    return acc;
  endfunction

endpackage

// File: rtl/modred_weight_rom.sv
// Weight lookup T[idx][digit] for the digit-serial reducer.
// Contents are elaborated from the package functions; maps to distributed logic.
module modred_weight_rom
  import modred_pkg::*;
#(
  parameter logic [63:0] Q       = 64'd549824583172097,
  parameter int          Q_W     = 49,
  parameter int          DIGIT_W = 5,
  parameter int          NDIG    = 20,
  parameter int          IDX_W   = 5
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic [DIGIT_W-1:0] digit,
  output logic [Q_W-1:0]     weight
);

  localparam int DEPTH = 2 ** DIGIT_W;

  logic [Q_W-1:0] tbl [NDIG][DEPTH];

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_pos
    for (genvar gd = 0; gd < DEPTH; gd++) begin : g_dig
      assign tbl[gi][gd] = Q_W'(table_entry(gi, gd, DIGIT_W, Q));
    end
  end

  // Positions past the last digit never occur in RUN; return zero for safety.
  always_comb begin
    weight = '0;
    if (32'(idx) < NDIG) weight = tbl[idx][digit];
  end

endmodule

// File: rtl/modred_digit_serial.sv
// Digit-serial modular reducer: out_data = in_data mod Q, one DIGIT_W digit per cycle.
// Optional feature: define MODRED_EARLY_EXIT_EN to finish as soon as all remaining digits are zero.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | accumulating one digit weight per cycle
// DONE  | result presented, waiting for out_ready
module modred_digit_serial
  import modred_pkg::*;
#(
  parameter logic [63:0] Q       = 64'd549824583172097,
  parameter int          Q_W     = 49,
  parameter int          IN_W    = 98,
  parameter int          DIGIT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Q_W-1:0]  out_data,
  output logic            busy
);

  localparam int NDIG  = ceil_div(IN_W, DIGIT_W);
  localparam int PAD_W = NDIG * DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [Q_W:0]     Q_EXT    = Q[Q_W:0];

  state_t           state;
  logic [PAD_W-1:0] opnd;
  logic [Q_W-1:0]   acc;
  logic [IDX_W-1:0] idx;
  logic [Q_W-1:0]   weight;
  logic [Q_W:0]     sum;
  logic [Q_W-1:0]   acc_next;
  logic             run_end;

  // The operand register is padded so the top digit is zero-extended.
  modred_weight_rom #(
    .Q       (Q),
    .Q_W     (Q_W),
    .DIGIT_W (DIGIT_W),
    .NDIG    (NDIG),
    .IDX_W   (IDX_W)
  ) u_rom (
    .idx    (idx),
    .digit  (opnd[DIGIT_W-1:0]),
    .weight (weight)
  );

  // Modular add: both inputs are below Q, so a single conditional subtract suffices.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, weight};
    acc_next = sum[Q_W-1:0];
    if (sum >= Q_EXT) acc_next = Q_W'(sum - Q_EXT);
  end

`ifdef MODRED_EARLY_EXIT_EN
  assign run_end = (idx == LAST_IDX) || ((opnd >> DIGIT_W) == '0);
`else
  assign run_end = (idx == LAST_IDX);
`endif

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // Control FSM with operand shift register, accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opnd      <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opnd <= PAD_W'(in_data);
            acc  <= '0;
            idx  <= '0;
`ifdef MODRED_EARLY_EXIT_EN
            if (in_data == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= '0;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          acc  <= acc_next;
          idx  <= idx + 1'b1;
          opnd <= opnd >> DIGIT_W;
          if (run_end) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modred_digit_serial.sv
// Self-checking bench for modred_digit_serial: bignum reference model, per-cycle compare
// process, literal spot checks, backpressure, mid-run reset and back-to-back throughput.
module tb_modred_digit_serial;

  localparam int Q_W     = 49;
  localparam int IN_W    = 98;
  localparam int DIGIT_W = 5;
  localparam int NDIG    = 20;
  localparam logic [127:0] QB = 128'd549824583172097;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [Q_W-1:0]  out_data;
  logic            busy;

  int     nchk = 0;
  int     nfail = 0;
  longint cyc = 0;
  bit     rnd_on = 1'b0;

  modred_digit_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [Q_W-1:0] ref_mod(input logic [IN_W-1:0] v);
    logic [127:0] b;
    b = 128'(v);
    return Q_W'(b % QB);
  endfunction

  // Cycles from accept to out_valid.
  function automatic int ref_lat(input logic [IN_W-1:0] v);
`ifdef MODRED_EARLY_EXIT_EN
    int top;
    logic [IN_W-1:0] t;
    top = -1;
    for (int k = 0; k < NDIG; k++) begin
      t = v >> (DIGIT_W * k);
      if (t[DIGIT_W-1:0] != '0) top = k;
    end
    return (top < 0) ? 1 : top + 2;
`else
    return (v == v) ? NDIG + 1 : NDIG + 1;
`endif
  endfunction

  function automatic logic [IN_W-1:0] rand_op();
    return IN_W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: tracks the single in-flight operand from the model's point of view.
  bit             pend = 1'b0;
  int             age = 0;
  int             lat = 0;
  logic [Q_W-1:0] expv = '0;
  longint         acc_cyc[$];

  always @(negedge clk) begin
    if (pend) begin
      age++;
      check("out_valid timing", 64'(out_valid), 64'(age >= lat));
      if (out_valid) check("out_data", 64'(out_data), 64'(expv));
    end else begin
      check("out_valid idle", 64'(out_valid), 64'd0);
    end
    check("busy", 64'(busy), 64'(pend));
    check("in_ready", 64'(in_ready), 64'(!pend && !rst));
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && out_valid && out_ready) pend = 1'b0;
      if (in_valid && in_ready) begin
        pend = 1'b1;
        age  = 0;
        lat  = ref_lat(in_data);
        expv = ref_mod(in_data);
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Presents an operand; returns just after the accepting edge.
  task automatic issue(input logic [IN_W-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = rand_op();
  endtask

  task automatic check_lit(input string name, input logic [IN_W-1:0] v,
                           input logic [Q_W-1:0] exp, input int exp_lat);
    int n;
    issue(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " value"}, 64'(out_data), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [IN_W-1:0] v;
    logic [127:0]    sq;
    logic [Q_W-1:0]  held;
    int              n;
    int              seen;
    longint          gaps[$];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Hand-computed expectations.
`ifdef MODRED_EARLY_EXIT_EN
    check_lit("zero", '0, '0, 1);
`else
    check_lit("zero", '0, '0, 21);
`endif
    check_lit("q-1", IN_W'(QB - 128'd1), Q_W'(QB - 128'd1), ref_lat(IN_W'(QB - 128'd1)));
    check_lit("q", IN_W'(QB), '0, ref_lat(IN_W'(QB)));
    check_lit("q+5", IN_W'(QB + 128'd5), Q_W'(5), ref_lat(IN_W'(QB + 128'd5)));
    // 2^49 - Q
    v = '0;
    v[49] = 1'b1;
    check_lit("2^49", v, Q_W'(64'd13125370249215), ref_lat(v));
    sq = (QB - 128'd1) * (QB - 128'd1);
    check_lit("(q-1)^2", IN_W'(sq), Q_W'(1), ref_lat(IN_W'(sq)));
    v = '1;
    check_lit("2^98-1", v, ref_mod(v), ref_lat(v));
    check_lit("31", IN_W'(31), Q_W'(31), ref_lat(IN_W'(31)));

    // Backpressure: result frozen, no new accept while DONE.
    out_ready = 1'b0;
    v = rand_op();
    issue(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("bp valid", 64'(out_valid), 64'd1);
    held = out_data;
    check("bp value", 64'(held), 64'(ref_mod(v)));
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = rand_op();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold data", 64'(out_data), 64'(held));
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset while RUN is at digit 7: that operand must never produce a result.
    v = rand_op();
    v[IN_W-1] = 1'b1;
    issue(v);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("aborted op out_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    v = rand_op();
    check_lit("after reset", v, ref_mod(v), ref_lat(v));

    // Randomized operands of varied magnitude with random backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      int bits;
      bits = $urandom_range(0, IN_W);
      v = rand_op();
      v = (bits == 0) ? '0 : (v >> (IN_W - bits));
      issue(v);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(out_valid && out_ready) && n < 300);
      if (n >= 300) check("random handshake timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: in_valid held high, accepts must be NDIG+2 cycles apart.
    acc_cyc.delete();
    in_valid = 1'b1;
    v = rand_op();
    v[IN_W-1] = 1'b1;
    in_data = v;
    n = 0;
    while (acc_cyc.size() < 4 && n < 200) begin
      @(negedge clk);
      seen = acc_cyc.size();
      @(posedge clk);
      #1;
      if (acc_cyc.size() != seen) begin
        v = rand_op();
        v[IN_W-1] = 1'b1;
        in_data = v;
      end
      n++;
    end
    in_valid = 1'b0;
    check("b2b accept count", 64'(acc_cyc.size()), 64'd4);
    for (int k = 0; k + 1 < acc_cyc.size(); k++) gaps.push_back(acc_cyc[k+1] - acc_cyc[k]);
    foreach (gaps[k]) check("b2b spacing", 64'(gaps[k]), 64'(NDIG + 2));
    repeat (30) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
